// File: rtl/dm_lane_mem.sv
// dm_lane_mem: M-stage data memory with byte/half lanes and a reset sweep.
// Optional store trace enabled by defining DM_TRACE_EN.
module dm_lane_mem #(
  parameter int ADDR_W   = 10,
  parameter int CLR_LAST = (1 << ADDR_W) - 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic [31:0] DIn,
  input  logic        MemWrite,
  input  logic [1:0]  Width,
  input  logic        LoadSigned,
  input  logic [31:0] PC,
  output logic [31:0] DO,
  output logic        AlignErr,
  output logic        Ready
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST =
    CLR_LAST[ADDR_W-1:0];

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [31:0]       mem [DEPTH];

  logic [ADDR_W-1:0] idx;
  logic [31:0]       cur;
  logic [31:0]       merged;
  logic [7:0]        bsel;
  logic [15:0]       hsel;
  logic [4:0]        boff;
  logic [4:0]        hoff;
  logic              is_word;
  logic              is_half;
  logic              is_byte;
  logic              wr_ok;

  assign idx  = Addr[ADDR_W+1:2];
  assign cur  = mem[idx];
  assign boff = {Addr[1:0], 3'b000};
  assign hoff = {Addr[1], 4'b0000};
  assign bsel = cur[boff +: 8];
  assign hsel = cur[hoff +: 16];

  assign is_half = (Width == 2'b01);
  assign is_byte = (Width == 2'b10);
  assign is_word = !is_half && !is_byte;

  always_comb begin
    AlignErr = 1'b0;
    unique case (1'b1)
      is_word: AlignErr = (Addr[1:0] != 2'b00);
      is_half: AlignErr = Addr[0];
      is_byte: AlignErr = 1'b0;
    endcase
  end

  always_comb begin
    merged = cur;
    unique case (1'b1)
      is_word: merged = DIn;
      is_half: merged[hoff +: 16] = DIn[15:0];
      is_byte: merged[boff +: 8] = DIn[7:0];
    endcase
  end

  always_comb begin
    DO = cur;
    unique case (1'b1)
      is_word: DO = cur;
      is_half: DO = {{16{LoadSigned & hsel[15]}}, hsel};
      is_byte: DO = {{24{LoadSigned & bsel[7]}}, bsel};
    endcase
  end

  assign wr_ok = (state == RUN) && MemWrite && !AlignErr;
  assign Ready = (state == RUN);

  // RUN encodes as 0 so a zero power-up state accepts stores.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else if (state == CLEAR) begin
      mem[cnt] <= '0;
      cnt      <= cnt + 1'b1;
      if (cnt == LAST)
        state <= RUN;
    end else if (wr_ok) begin
      mem[idx] <= merged;
`ifdef DM_TRACE_EN
      $display("%d@%h: *%h <= %h", $time, PC,
               {Addr[31:2], 2'b00}, merged);
`endif
    end
  end

`ifdef DM_TRACE_EN
  logic unused_hi;
  assign unused_hi = ^Addr[31:ADDR_W+2];
`else
  logic unused_hi;
  assign unused_hi = ^{PC, Addr[31:ADDR_W+2]};
`endif

endmodule

// File: tb/tb_dm_lane_mem.sv
// tb_dm_lane_mem: directed checks of lanes, extension,
// alignment and the reset sweep of dm_lane_mem.
module tb_dm_lane_mem;

  logic        clk;
  logic        reset;
  logic [31:0] Addr;
  logic [31:0] DIn;
  logic        MemWrite;
  logic [1:0]  Width;
  logic        LoadSigned;
  logic [31:0] PC;
  logic [31:0] DO;
  logic        AlignErr;
  logic        Ready;

  int tests = 0;
  int fails = 0;
  int n;

  dm_lane_mem dut (
    .clk        (clk),
    .reset      (reset),
    .Addr       (Addr),
    .DIn        (DIn),
    .MemWrite   (MemWrite),
    .Width      (Width),
    .LoadSigned (LoadSigned),
    .PC         (PC),
    .DO         (DO),
    .AlignErr   (AlignErr),
    .Ready      (Ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a,
                    input logic [1:0] w,
                    input logic s);
    MemWrite   = 1'b0;
    Addr       = a;
    Width      = w;
    LoadSigned = s;
    #1;
  endtask

  task automatic st(input logic [31:0] a,
                    input logic [31:0] d,
                    input logic [1:0] w);
    Addr     = a;
    DIn      = d;
    Width    = w;
    MemWrite = 1'b1;
    tick();
    MemWrite = 1'b0;
  endtask

  task automatic sweep(input string tag);
    n = 0;
    while (!Ready && n < 2000) begin
      tick();
      n++;
    end
    chk(tag, n, 1024);
  endtask

  initial begin
    reset      = 1'b1;
    Addr       = '0;
    DIn        = '0;
    MemWrite   = 1'b0;
    Width      = 2'b00;
    LoadSigned = 1'b0;
    PC         = '0;

    tick();
    chk("rst_ready", {31'd0, Ready}, 32'd0);
    reset = 1'b0;
    sweep("sweep0_len");

    st(32'h14, 32'hDEADBEEF, 2'b00);
    st(32'h00, 32'h0BADF00D, 2'b00);
    rd(32'h14, 2'b00, 1'b0);
    chk("preload5", DO, 32'hDEADBEEF);

    reset = 1'b1;
    tick();
    tick();
    chk("hold_ready", {31'd0, Ready}, 32'd0);
    rd(32'h00, 2'b00, 1'b0);
    chk("hold_noclr", DO, 32'h0BADF00D);
    reset = 1'b0;
    sweep("sweep1_len");
    rd(32'h14, 2'b00, 1'b0);
    chk("swept5", DO, 32'h0);
    rd(32'h00, 2'b00, 1'b0);
    chk("swept0", DO, 32'h0);

    st(32'h20, 32'h11223344, 2'b00);
    rd(32'h20, 2'b00, 1'b0);
    chk("word_st", DO, 32'h11223344);
    st(32'h21, 32'h000000AA, 2'b10);
    rd(32'h20, 2'b00, 1'b0);
    chk("byte_mrg", DO, 32'h1122AA44);
    st(32'h22, 32'h0000BEEF, 2'b01);
    rd(32'h20, 2'b00, 1'b0);
    chk("half_mrg", DO, 32'hBEEFAA44);
    rd(32'h1020, 2'b00, 1'b0);
    chk("wrap", DO, 32'hBEEFAA44);

    Addr     = 32'h24;
    DIn      = 32'h00000055;
    Width    = 2'b00;
    MemWrite = 1'b1;
    #1;
    chk("rdw_old", DO, 32'h0);
    tick();
    MemWrite = 1'b0;
    chk("rdw_new", DO, 32'h55);

    st(32'h40, 32'h80FF7F01, 2'b00);
    rd(32'h41, 2'b10, 1'b1);
    chk("b41_s", DO, 32'h0000007F);
    rd(32'h43, 2'b10, 1'b1);
    chk("b43_s", DO, 32'hFFFFFF80);
    rd(32'h43, 2'b10, 1'b0);
    chk("b43_u", DO, 32'h00000080);
    rd(32'h42, 2'b01, 1'b0);
    chk("h42_u", DO, 32'h000080FF);
    rd(32'h42, 2'b01, 1'b1);
    chk("h42_s", DO, 32'hFFFF80FF);
    rd(32'h40, 2'b10, 1'b0);
    chk("b40_u", DO, 32'h00000001);
    rd(32'h40, 2'b11, 1'b1);
    chk("w11", DO, 32'h80FF7F01);

    st(32'h60, 32'h600DCAFE, 2'b00);
    Addr     = 32'h61;
    DIn      = 32'h00001111;
    Width    = 2'b01;
    MemWrite = 1'b1;
    #1;
    chk("ae_h61", {31'd0, AlignErr}, 32'd1);
    tick();
    MemWrite = 1'b0;
    rd(32'h60, 2'b00, 1'b0);
    chk("h61_nowr", DO, 32'h600DCAFE);
    Addr     = 32'h62;
    DIn      = 32'h22222222;
    Width    = 2'b00;
    MemWrite = 1'b1;
    #1;
    chk("ae_w62", {31'd0, AlignErr}, 32'd1);
    tick();
    MemWrite = 1'b0;
    rd(32'h60, 2'b00, 1'b0);
    chk("w62_nowr", DO, 32'h600DCAFE);
    rd(32'h62, 2'b01, 1'b0);
    chk("ae_h62", {31'd0, AlignErr}, 32'd0);
    rd(32'h63, 2'b10, 1'b0);
    chk("ae_b63", {31'd0, AlignErr}, 32'd0);
    rd(32'h61, 2'b01, 1'b0);
    chk("mis_ld", DO, 32'h0000CAFE);

    st(32'hFA0, 32'h12345678, 2'b00);
    st(32'h320, 32'h77777777, 2'b00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 300; i++) tick();
    chk("mid_ready", {31'd0, Ready}, 32'd0);
    st(32'hFA0, 32'hCAFEF00D, 2'b00);
    rd(32'hFA0, 2'b00, 1'b0);
    chk("clr_nowr", DO, 32'h12345678);
    rd(32'h320, 2'b00, 1'b0);
    chk("clr_done", DO, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sweep("sweep2_len");
    rd(32'hFA0, 2'b00, 1'b0);
    chk("fa0_zero", DO, 32'h0);

    PC = 32'h3000;
    st(32'h1003, 32'h0000005A, 2'b10);
    rd(32'h1000, 2'b00, 1'b0);
    chk("trace_st", DO, 32'h5A000000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dm_lane_mem.md
# dm_lane_mem

Parametrised data memory for the MIPS pipeline's M stage. Successor to the fixed 1024-word, word-only data memory. Adds:
- configurable depth;
- byte and halfword stores with lane merging;
- sign- or zero-extended sub-word loads;
- alignment checking;
- a one-word-per-cycle reset sweep with a `Ready` handshake, replacing the single-cycle bulk clear.

Sits between the M-stage ALU result/forwarded rt value and the M/W pipeline register.

## Interface
Parameters:
- `ADDR_W`, default 10: word-address bits. Depth = 2^ADDR_W words of 32 bits.
- `CLR_LAST`, default 2^ADDR_W−1: last word index cleared by the reset sweep. Must satisfy CLR_LAST < 2^ADDR_W.

Ports:
- `clk` — input, 1 — one clock; all state changes on posedge.
- `reset` — input, 1 — synchronous, active-high.
- `Addr` — input, 32 — byte address.
  - Word index = `Addr[ADDR_W+1:2]`.
  - Upper bits are ignored, so addresses wrap modulo depth.
- `DIn` — input, 32 — store data, right-justified for sub-word stores.
- `MemWrite` — input, 1 — store request, sampled at posedge.
- `Width` — input, 2 — access size.
  - 00 = word, 01 = half, 10 = byte.
  - 11 is treated as word.
- `LoadSigned` — input, 1 — 1 = sign-extend sub-word loads, 0 = zero-extend.
- `PC` — input, 32 — address of the instruction in M. Used for trace only.
- `DO` — output, 32 — load data, already extracted and extended.
- `AlignErr` — output, 1 — combinational.
  - Asserts for half with `Addr[0]`=1.
  - Asserts for word with `Addr[1:0]`≠0.
- `Ready` — output, 1 — 1 when the memory accepts stores; 0 during the reset sweep.

## Operation
- **States:** CLEAR, RUN.
  - Power-up: all words 0, state RUN, `Ready`=1.
- **Reset:** `reset`=1 at posedge → state CLEAR, clear counter `cnt`=0, `Ready`=0.
  - Applies from any state, including mid-sweep; the sweep always restarts at 0.
- **CLEAR:**
  - Each posedge with `reset`=0 writes 0 to word `cnt`, then `cnt`++.
  - On the edge that clears word CLR_LAST → RUN.
  - During CLEAR, `MemWrite` is ignored entirely and no trace is emitted.
  - While `reset` is held high, no words are cleared; `cnt` stays 0.
- **RUN store:** on posedge with `MemWrite`=1 and `AlignErr`=0, the selected word is read, merged and written back.
  - Word: whole word ← `DIn`.
  - Half: lane `Addr[1]` (0 = bits 15:0, 1 = bits 31:16) ← `DIn[15:0]`. Other half unchanged.
  - Byte: lane `Addr[1:0]` (0 = bits 7:0 … 3 = bits 31:24) ← `DIn[7:0]`. Other lanes unchanged.
- **Misaligned store:** `MemWrite`=1 with `AlignErr`=1 → no write. `AlignErr` is visible to the hazard/exception logic.
- **Load (`DO`), combinational from current array contents:**
  - Word: the stored word.
  - Half: selected half, extended to 32 bits per `LoadSigned`.
  - Byte: selected byte, extended to 32 bits per `LoadSigned`.
  - A misaligned load still returns the lane selected by the low address bits; `AlignErr` flags it.
- **Reads during CLEAR:** return current contents. Words already swept read 0; words not yet swept read old data. The pipeline must stall on `Ready`=0.

## Timing
- Store latency: 1 edge. New data is visible on `DO` immediately after the writing posedge.
- Read-during-write, same address: `DO` shows old data before the edge and merged data after it.
- Sweep length: CLR_LAST+1 cycles after `reset` deasserts. `Ready` rises on the edge that clears word CLR_LAST.
  - With defaults, `Ready`=1 exactly 1024 edges after the first edge with `reset`=0.
- Output values during and after reset:
  - `Ready`=0 from the reset edge until the sweep completes.
  - `DO` and `AlignErr` are combinational and never registered.
  - After a complete sweep, `DO`=0 for any in-range address.

## Configuration
- `DM_TRACE_EN` defined: each accepted RUN store executes `$display("%d@%h: *%h <= %h", $time, PC, {Addr[31:2],2'b00}, merged_word)`. The printed value is the full 32-bit word after merge.
- `DM_TRACE_EN` undefined: no display statements are compiled, and the `PC` port is unused. Functional behaviour is identical.

## Test plan
- **Reset sweep:** preload word 5 = 0xDEADBEEF; reset 1 cycle; stall.
  - `Ready`=0 for 1024 edges, then 1.
  - `Addr`=0x14 → `DO`=0.
- **Byte/half merge:**
  - Store word 0x11223344 at 0x20.
  - Store byte 0xAA at 0x21 → `DO` (word at 0x20) = 0x1122AA44.
  - Store half 0xBEEF at 0x22 → `DO` = 0xBEEFAA44.
- **Extension:** word 0x80FF7F01 at 0x40.
  - Byte at 0x41, signed → 0xFFFFFF7F? No: lane 1 is 0x7F → 0x0000007F.
  - Byte at 0x43, signed → 0xFFFFFF80.
  - Half at 0x42, unsigned → 0x000080FF.
- **Misalignment:** store half at 0x61 with `MemWrite`=1 → `AlignErr`=1, word at 0x60 unchanged; word store at 0x62 → also rejected.
- **Reset mid-sweep and ignored stores:** assert reset at sweep cycle 300; sweep restarts. A store issued during CLEAR has no effect, and `Ready` rises 1024 edges after the second reset.
- **Trace (DM_TRACE_EN):** `PC`=0x3000, store byte 0x5A to 0x1003 (word initially 0) → one line reporting address 0x00001000 and data 0x5a000000.
